// File: rtl/conv2d_stream_param_if.sv
// rtl/conv2d_stream_param_if.sv - signal bundle for the streaming 2-D convolution engine
// Purpose: groups the kernel-load, pixel-input and result-output signals of conv2d_stream_param.
// Ports (slave = engine side, master = feeder/consumer side):
//   load_kernel, kernel               kernel coefficient stream into the engine
//   load_kernel_done                  engine holds a complete kernel
//   data_valid_in, data_in            raster-order pixel stream into the engine
//   data_out, valid_out, frame_done   result stream out of the engine
interface conv2d_stream_param_if #(
  parameter int DATA_W = 32,
  parameter int K      = 5
);
  localparam int ACC_W = 2*DATA_W + $clog2(K*K);

  logic              load_kernel;
  logic [DATA_W-1:0] kernel;
  logic              load_kernel_done;
  logic              data_valid_in;
  logic [DATA_W-1:0] data_in;
  logic [ACC_W-1:0]  data_out;
  logic              valid_out;
  logic              frame_done;

  modport master (
    output load_kernel, kernel, data_valid_in, data_in,
    input  load_kernel_done, data_out, valid_out, frame_done
  );

  modport slave (
    input  load_kernel, kernel, data_valid_in, data_in,
    output load_kernel_done, data_out, valid_out, frame_done
  );
endinterface

// File: rtl/conv2d_stream_param.sv
// rtl/conv2d_stream_param.sv - parametrised streaming KxK convolution with stride
// Purpose: loads a KxK signed kernel serially, then convolves a raster IMG_W x IMG_H pixel
//   stream, emitting one signed dot product per strided valid window (no padding).
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous reset, active-high
//   bus  conv2d_stream_param_if.slave (kernel load, pixel stream, result stream)
// Optional build macro: CONV2D_RELU_EN clamps negative results to zero.
module conv2d_stream_param #(
  parameter int DATA_W = 32,
  parameter int K      = 5,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  conv2d_stream_param_if.slave bus
);
  localparam int ACC_W  = 2*DATA_W + $clog2(K*K);
  localparam int NK     = K*K;
  localparam int PW     = 2*DATA_W;
  localparam int IDX_W  = $clog2(NK);
  localparam int CI_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RI_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PH_W   = $clog2(STRIDE + 1);
  // Position of the last emitted window of a frame (bottom-right strided window).
  localparam int LAST_R = (K-1) + ((IMG_H-K)/STRIDE)*STRIDE;
  localparam int LAST_C = (K-1) + ((IMG_W-K)/STRIDE)*STRIDE;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              lk_q;
  logic [CI_W-1:0]   col;
  logic [RI_W-1:0]   row;
  logic [PH_W-1:0]   cph;
  logic [PH_W-1:0]   rph;
  logic              s1_valid;
  logic              s1_last;

  logic [DATA_W-1:0] coef   [NK];
  logic [DATA_W-1:0] win    [K][K];
  logic [DATA_W-1:0] lb     [K-1][IMG_W];
  logic [PW-1:0]     prod_q [NK];

  logic [DATA_W-1:0] col_in [K];
  logic [DATA_W-1:0] win_nx [K][K];
  logic [PW-1:0]     prod_d [NK];
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  result;
  logic              restart, accept, emit, is_last, load_start, coef_we;
  logic [IDX_W-1:0]  coef_wa;

  always_comb begin
    // A reload from RUN needs a fresh rising load_kernel, so words beyond K*K are ignored.
    restart    = (state == RUN) && bus.load_kernel && !lk_q;
    load_start = ((state == IDLE) && bus.load_kernel) || restart;
    coef_we    = load_start || ((state == LOAD) && bus.load_kernel);
    coef_wa    = load_start ? '0 : idx;
    accept     = (state == RUN) && bus.data_valid_in && !restart;
    emit       = accept && (row >= RI_W'(K-1)) && (col >= CI_W'(K-1)) &&
                 (rph == '0) && (cph == '0);
    is_last    = (row == RI_W'(LAST_R)) && (col == CI_W'(LAST_C));

    // Incoming column: oldest row from lb[0], current row straight from the input.
    col_in[K-1] = bus.data_in;
    for (int j = 0; j < K-1; j++) col_in[j] = lb[j][col];

    // Window as it will look after this pixel; products are taken from it directly so the
    // result lands two cycles after the completing pixel.
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) win_nx[r][c] = win[r][c+1];
      win_nx[r][K-1] = col_in[r];
    end

    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        prod_d[r*K+c] = {{DATA_W{win_nx[r][c][DATA_W-1]}}, win_nx[r][c]} *
                        {{DATA_W{coef[r*K+c][DATA_W-1]}}, coef[r*K+c]};

    sum = '0;
    for (int i = 0; i < NK; i++)
      sum = sum + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};

`ifdef CONV2D_RELU_EN
    result = sum[ACC_W-1] ? '0 : sum;
`else
    result = sum;
`endif
  end

  // Control, counters and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state                <= IDLE;
      idx                  <= '0;
      lk_q                 <= 1'b0;
      col                  <= '0;
      row                  <= '0;
      cph                  <= '0;
      rph                  <= '0;
      s1_valid             <= 1'b0;
      s1_last              <= 1'b0;
      bus.data_out         <= '0;
      bus.valid_out        <= 1'b0;
      bus.frame_done       <= 1'b0;
      bus.load_kernel_done <= 1'b0;
    end else begin
      lk_q <= bus.load_kernel;

      case (state)
        IDLE: if (bus.load_kernel) begin
          idx   <= IDX_W'(1);
          state <= LOAD;
        end
        LOAD: if (!bus.load_kernel) begin
          idx   <= '0;
          state <= IDLE;
        end else if (idx == IDX_W'(NK-1)) begin
          idx                  <= '0;
          state                <= RUN;
          bus.load_kernel_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
        RUN: if (restart) begin
          idx                  <= IDX_W'(1);
          state                <= LOAD;
          bus.load_kernel_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (restart) begin
        col <= '0;
        row <= '0;
        cph <= '0;
        rph <= '0;
      end else if (accept) begin
        if (col == CI_W'(IMG_W-1)) begin
          col <= '0;
          cph <= '0;
          if (row == RI_W'(IMG_H-1)) begin
            row <= '0;
            rph <= '0;
          end else begin
            row <= row + 1'b1;
            if (row >= RI_W'(K-1)) rph <= (rph == PH_W'(STRIDE-1)) ? '0 : rph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col >= CI_W'(K-1)) cph <= (cph == PH_W'(STRIDE-1)) ? '0 : cph + 1'b1;
        end
      end

      s1_valid       <= emit;
      s1_last        <= emit && is_last;
      // A restart also kills the result already in stage 1.
      bus.valid_out  <= s1_valid && !restart;
      bus.frame_done <= s1_valid && s1_last && !restart;
      if (s1_valid && !restart) bus.data_out <= result;
    end
  end

  // Storage that is deliberately never cleared.
  always_ff @(posedge CLK) begin
    if (coef_we) coef[coef_wa] <= bus.kernel;
    if (accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= win_nx[r][c];
      for (int j = 0; j < K-2; j++) lb[j][col] <= lb[j+1][col];
      lb[K-2][col] <= bus.data_in;
    end
    if (emit)
      for (int i = 0; i < NK; i++) prod_q[i] <= prod_d[i];
  end
endmodule

// File: tb/tb_conv2d_stream_param.sv
// tb/tb_conv2d_stream_param.sv - self-checking bench for conv2d_stream_param
module tb_conv2d_stream_param;
  typedef struct {
    longint val;
    logic   last;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   img [1024];
  int   kern [32];
  exp_t qa [$];
  exp_t qb [$];
  exp_t qc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_stream_param_if #(.DATA_W(32), .K(3)) ia ();
  conv2d_stream_param_if #(.DATA_W(32), .K(3)) ib ();
  conv2d_stream_param_if #(.DATA_W(32), .K(5)) ic ();

  conv2d_stream_param #(.DATA_W(32), .K(3), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
    .CLK(clk), .RST(rst), .bus(ia.slave));
  conv2d_stream_param #(.DATA_W(32), .K(3), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
    .CLK(clk), .RST(rst), .bus(ib.slave));
  conv2d_stream_param dut_c (
    .CLK(clk), .RST(rst), .bus(ic.slave));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return ia.load_kernel_done;
      1:       return ib.load_kernel_done;
      default: return ic.load_kernel_done;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic lk, input logic [31:0] kv,
                        input logic dv, input logic [31:0] dd);
    case (sel)
      0: begin ia.load_kernel = lk; ia.kernel = kv; ia.data_valid_in = dv; ia.data_in = dd; end
      1: begin ib.load_kernel = lk; ib.kernel = kv; ib.data_valid_in = dv; ib.data_in = dd; end
      default: begin ic.load_kernel = lk; ic.kernel = kv; ic.data_valid_in = dv; ic.data_in = dd; end
    endcase
  endtask

  // Reference convolution of the window whose top-left pixel is (r0,c0).
  function automatic longint model(input int k, input int w, input int r0, input int c0);
    longint acc = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        acc += longint'(kern[i*k+j]) * longint'(img[(r0+i)*w + c0 + j]);
`ifdef CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic mon(input int sel, input logic v, input logic [127:0] d, input logic fd);
    exp_t e;
    if (v) begin
      if (qsize(sel) == 0) begin
        check($sformatf("u%0d_spurious_valid", sel), 128'(v), 128'(0));
      end else begin
        case (sel)
          0:       e = qa.pop_front();
          1:       e = qb.pop_front();
          default: e = qc.pop_front();
        endcase
        check($sformatf("u%0d_data", sel), d, 128'(e.val));
        check($sformatf("u%0d_frame_done", sel), 128'(fd), 128'(e.last));
        check($sformatf("u%0d_latency_cycle", sel), 128'(cyc), 128'(e.due));
      end
    end else if (qsize(sel) != 0) begin
      case (sel)
        0:       e = qa[0];
        1:       e = qb[0];
        default: e = qc[0];
      endcase
      if (e.due < cyc) begin
        check($sformatf("u%0d_missed_valid", sel), 128'(v), 128'(1));
        case (sel)
          0:       void'(qa.pop_front());
          1:       void'(qb.pop_front());
          default: void'(qc.pop_front());
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.valid_out, 128'($signed(ia.data_out)), ia.frame_done);
    mon(1, ib.valid_out, 128'($signed(ib.data_out)), ib.frame_done);
    mon(2, ic.valid_out, 128'($signed(ic.data_out)), ic.frame_done);
  end

  task automatic idle(input int sel);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic load(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_in(sel, 1'b1, kern[i], 1'b0, 32'd0);
    end
  endtask

  task automatic load_full(input int sel, input int n);
    load(sel, n);
    check($sformatf("u%0d_done_during_load", sel), 128'(get_done(sel)), 128'(0));
    idle(sel);
    check($sformatf("u%0d_done_after_load", sel), 128'(get_done(sel)), 128'(1));
  endtask

  task automatic drive_frame(input int sel, input int k, input int w, input int h, input int s,
                             input bit gaps, input int npix, input bit exp_on);
    int   r, c, lr, lc;
    exp_t e;
    lr = k - 1 + ((h - k) / s) * s;
    lc = k - 1 + ((w - k) / s) * s;
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(1, 0) == 0) begin
        @(posedge clk); #1;
        set_in(sel, 1'b0, 32'd0, 1'b0, 32'd0);
      end
      @(posedge clk); #1;
      set_in(sel, 1'b0, 32'd0, 1'b1, img[i]);
      r = i / w;
      c = i % w;
      if (exp_on && r >= k-1 && c >= k-1 && (r-k+1) % s == 0 && (c-k+1) % s == 0) begin
        e.val  = model(k, w, r-k+1, c-k+1);
        e.last = (r == lr) && (c == lc);
        e.due  = cyc + 2;
        case (sel)
          0:       qa.push_back(e);
          1:       qb.push_back(e);
          default: qc.push_back(e);
        endcase
      end
    end
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 20 && qsize(sel) != 0; i++) @(negedge clk);
    @(negedge clk);
    check($sformatf("u%0d_drain_pending", sel), 128'(qsize(sel)), 128'(0));
  endtask

  initial begin
    #10000000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", 128'(ia.valid_out), 128'(0));
    check("rst_dout_a", 128'($signed(ia.data_out)), 128'(0));
    check("rst_frame_done_a", 128'(ia.frame_done), 128'(0));
    check("rst_done_a", 128'(ia.load_kernel_done), 128'(0));
    check("rst_done_b", 128'(ib.load_kernel_done), 128'(0));
    check("rst_done_c", 128'(ic.load_kernel_done), 128'(0));
    rst = 1'b0;

    // Partial load is discarded.
    for (int i = 0; i < 32; i++) kern[i] = 7;
    load(0, 4);
    idle(0);
    check("partial_load_done", 128'(get_done(0)), 128'(0));

    // All-ones kernel with two extra words held on the bus; pixels 1..16.
    for (int i = 0; i < 32; i++) kern[i] = (i < 9) ? 1 : 100;
    load(0, 11);
    idle(0);
    check("done_after_extra_words", 128'(get_done(0)), 128'(1));
    for (int i = 0; i < 16; i++) img[i] = i + 1;
    drive_frame(0, 3, 4, 4, 1, 1'b0, 16, 1'b1);
    idle(0);
    drain(0);
    check("hold_last_99", 128'($signed(ia.data_out)), 128'(99));
    check("idle_valid_low", 128'(ia.valid_out), 128'(0));

    // Next frame straight after the wrap, no reload.
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(200)) - 100;
    drive_frame(0, 3, 4, 4, 1, 1'b0, 16, 1'b1);
    idle(0);
    drain(0);

    // Reset after 7 coefficients of a load.
    for (int i = 0; i < 9; i++) kern[i] = -1;
    load(0, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midload_rst_done", 128'(ia.load_kernel_done), 128'(0));
    check("midload_rst_valid", 128'(ia.valid_out), 128'(0));
    check("midload_rst_dout", 128'($signed(ia.data_out)), 128'(0));
    check("midload_rst_frame_done", 128'(ia.frame_done), 128'(0));
    rst = 1'b0;
    idle(0);

    // All -1 kernel, constant 5 pixels.
    load_full(0, 9);
    for (int i = 0; i < 16; i++) img[i] = 5;
    drive_frame(0, 3, 4, 4, 1, 1'b0, 16, 1'b1);
    idle(0);
    drain(0);
`ifdef CONV2D_RELU_EN
    check("neg_sum_hold", 128'($signed(ia.data_out)), 128'(0));
`else
    check("neg_sum_hold", 128'($signed(ia.data_out)), -128'sd45);
`endif

    // Abort right after the pixel completing the first window, reload, fresh frame.
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(50));
    drive_frame(0, 3, 4, 4, 1, 1'b0, 11, 1'b0);
    kern[0] = 1; kern[1] = -2; kern[2] = 3; kern[3] = 0; kern[4] = 1;
    kern[5] = 0; kern[6] = 2; kern[7] = -1; kern[8] = 1;
    load_full(0, 9);
    for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(200)) - 100;
    drive_frame(0, 3, 4, 4, 1, 1'b0, 16, 1'b1);
    idle(0);
    drain(0);

    // Stride 2 on a 5x5 frame.
    for (int i = 0; i < 9; i++) kern[i] = 1;
    load_full(1, 9);
    for (int i = 0; i < 25; i++) img[i] = i + 1;
    drive_frame(1, 3, 5, 5, 2, 1'b0, 25, 1'b1);
    idle(1);
    drain(1);

    // Default parameters, identity kernel, random frame with input gaps.
    for (int i = 0; i < 25; i++) kern[i] = (i == 12) ? 1 : 0;
    load_full(2, 25);
    for (int i = 0; i < 1024; i++) img[i] = int'($urandom);
    drive_frame(2, 5, 32, 32, 1, 1'b1, 1024, 1'b1);
    idle(2);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
